// File: rtl/dip_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dip_debounce_pkg
//  Description : Board timing constants for the DIP switch input conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
package dip_debounce_pkg;

    // 50 MHz board clock, 10 ms debounce window
    localparam int c_CLK_HZ          = 50_000_000;
    localparam int c_DEBOUNCE_MS     = 10;
    localparam int c_CNT_MAX_DEFAULT = (c_CLK_HZ / 1000) * c_DEBOUNCE_MS;

endpackage : dip_debounce_pkg
`default_nettype wire

// File: rtl/dip_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : dip_debounce_bit
//  Description : Two-flop synchroniser, qualification counter and change
//                pulse for a single DIP switch bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module dip_debounce_bit
    import dip_debounce_pkg::*;
#(
    parameter int CNT_MAX = c_CNT_MAX_DEFAULT,
    parameter int CW      = $clog2(CNT_MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic dip_raw,
    output logic dip,
    output logic dip_chg,
    output logic busy
);

    localparam logic [CW-1:0] c_LAST = CW'(CNT_MAX - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_dip;
    logic          r_chg;
    logic          r_busy;
    logic [CW-1:0] r_cnt;

    logic          w_dip_nxt;
    logic          w_chg_nxt;
    logic [CW-1:0] w_cnt_nxt;

    // Any return of s2 to the accepted level restarts the window from zero
    always_comb begin
        w_dip_nxt = r_dip;
        w_chg_nxt = 1'b0;
        w_cnt_nxt = '0;
        if (r_s2 != r_dip) begin
            if (r_cnt == c_LAST) begin
                w_dip_nxt = r_s2;
                w_chg_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_dip  <= 1'b0;
            r_chg  <= 1'b0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_s1   <= dip_raw;
            r_s2   <= r_s1;
            r_dip  <= w_dip_nxt;
            r_chg  <= w_chg_nxt;
            r_cnt  <= w_cnt_nxt;
            r_busy <= (w_cnt_nxt != '0);
        end
    end

    assign dip     = r_dip;
    assign dip_chg = r_chg;
    assign busy    = r_busy;

endmodule : dip_debounce_bit
`default_nettype wire

// File: rtl/dip_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : dip_debounce
//  Description : Synchronises and debounces a DIP switch bank, producing a
//                clean level vector, per-bit change pulses and a busy flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module dip_debounce
    import dip_debounce_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CNT_MAX = c_CNT_MAX_DEFAULT,
    parameter int CW      = $clog2(CNT_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dip_raw,
    output logic [WIDTH-1:0] dip,
    output logic [WIDTH-1:0] dip_chg,
    output logic             busy
);

    logic [WIDTH-1:0] w_busy;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            dip_debounce_bit #(
                .CNT_MAX (CNT_MAX),
                .CW      (CW)
            ) u_bit (
                .clk     (clk),
                .rst     (rst),
                .dip_raw (dip_raw[gi]),
                .dip     (dip[gi]),
                .dip_chg (dip_chg[gi]),
                .busy    (w_busy[gi])
            );
        end
    endgenerate

    // Per-bit flags are already registered, so the OR stays glitch-free
    assign busy = |w_busy;

endmodule : dip_debounce
`default_nettype wire

// File: tb/tb_dip_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dip_debounce
//  Description : Self-checking bench for dip_debounce (CNT_MAX=4 and CNT_MAX=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dip_debounce;

    localparam int c_W = 8;

    logic           clk;
    logic           rst;
    logic [c_W-1:0] dip_raw;
    logic [c_W-1:0] dip;
    logic [c_W-1:0] dip_chg;
    logic           busy;
    logic [c_W-1:0] dip1;
    logic [c_W-1:0] dip_chg1;
    logic           busy1;

    dip_debounce #(
        .WIDTH   (c_W),
        .CNT_MAX (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .dip_raw (dip_raw),
        .dip     (dip),
        .dip_chg (dip_chg),
        .busy    (busy)
    );

    dip_debounce #(
        .WIDTH   (c_W),
        .CNT_MAX (1)
    ) dut1 (
        .clk     (clk),
        .rst     (rst),
        .dip_raw (dip_raw),
        .dip     (dip1),
        .dip_chg (dip_chg1),
        .busy    (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic [c_W-1:0] raw;
        logic [c_W-1:0] dip;
        logic [c_W-1:0] chg;
        logic           busy;
    } vec_t;

    typedef struct {
        logic [c_W-1:0] dip;
        logic [c_W-1:0] chg;
        logic           busy;
        logic [c_W-1:0] dip1;
        logic [c_W-1:0] chg1;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int n_total = 0;
    int n_pass  = 0;

    // CNT_MAX=1 reference: dip follows the second sync stage one cycle later
    logic [c_W-1:0] m1, m2, md;

    task automatic check(input string name, input int step,
                         input logic [c_W-1:0] act, input logic [c_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    endtask

    task automatic add(input logic r, input logic [c_W-1:0] raw,
                       input logic [c_W-1:0] d, input logic [c_W-1:0] c, input logic b);
        vec_t v;
        v.rst = r; v.raw = raw; v.dip = d; v.chg = c; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic add_busy(input logic [c_W-1:0] raw, input logic [c_W-1:0] d,
                            input string pattern);
        for (int i = 0; i < pattern.len(); i++)
            add(1'b0, raw, d, 8'h00, pattern[i] == "1");
    endtask

    initial begin
        exp_t e;
        exp_t got;
        logic [c_W-1:0] nd;
        logic [c_W-1:0] dip_ref;
        logic           chg_seen;
        logic           busy_seen;
        logic           settled;

        rst     = 1'b1;
        dip_raw = '0;
        m1 = '0; m2 = '0; md = '0;

        // Reset with all switches high, then qualification after release
        for (int i = 0; i < 3; i++) add(1'b1, 8'hFF, 8'h00, 8'h00, 1'b0);
        add_busy(8'hFF, 8'h00, "00111");
        add(1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        add(1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0);
        // Clean step to 8'h05
        add(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        add_busy(8'h05, 8'h00, "00111");
        add(1'b0, 8'h05, 8'h05, 8'h05, 1'b0);
        add(1'b0, 8'h05, 8'h05, 8'h00, 1'b0);
        // Bounce on bit 3: 1,0,1,0 in 2-cycle phases, then steady 1
        add(1'b0, 8'h0D, 8'h05, 8'h00, 1'b0);
        add(1'b0, 8'h0D, 8'h05, 8'h00, 1'b0);
        add(1'b0, 8'h05, 8'h05, 8'h00, 1'b1);
        add(1'b0, 8'h05, 8'h05, 8'h00, 1'b1);
        add(1'b0, 8'h0D, 8'h05, 8'h00, 1'b0);
        add(1'b0, 8'h0D, 8'h05, 8'h00, 1'b0);
        add(1'b0, 8'h05, 8'h05, 8'h00, 1'b1);
        add(1'b0, 8'h05, 8'h05, 8'h00, 1'b1);
        add_busy(8'h0D, 8'h05, "00111");
        add(1'b0, 8'h0D, 8'h0D, 8'h08, 1'b0);
        add(1'b0, 8'h0D, 8'h0D, 8'h00, 1'b0);
        // 3-cycle glitch on bit 7
        add_busy(8'h8D, 8'h0D, "001");
        add_busy(8'h0D, 8'h0D, "11000");
        // Independence: bit 0 at t, bit 1 at t+2
        add(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        add_busy(8'h01, 8'h00, "00");
        add_busy(8'h03, 8'h00, "111");
        add(1'b0, 8'h03, 8'h01, 8'h01, 1'b1);
        add(1'b0, 8'h03, 8'h01, 8'h00, 1'b1);
        add(1'b0, 8'h03, 8'h03, 8'h02, 1'b0);
        add(1'b0, 8'h03, 8'h03, 8'h00, 1'b0);
        // Reset at cnt=2 during a pending rise on bit 4
        add(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        add_busy(8'h10, 8'h00, "0011");
        add(1'b1, 8'h10, 8'h00, 8'h00, 1'b0);
        add_busy(8'h10, 8'h00, "00111");
        add(1'b0, 8'h10, 8'h10, 8'h10, 1'b0);
        add(1'b0, 8'h10, 8'h10, 8'h00, 1'b0);

        foreach (vecs[k]) begin
            @(negedge clk);
            rst     = vecs[k].rst;
            dip_raw = vecs[k].raw;
            e.dip  = vecs[k].dip;
            e.chg  = vecs[k].chg;
            e.busy = vecs[k].busy;
            if (vecs[k].rst) begin
                m1 = '0; m2 = '0; md = '0;
                e.dip1 = '0;
                e.chg1 = '0;
            end else begin
                nd = m2;
                e.chg1 = nd ^ md;
                e.dip1 = nd;
                md = nd;
                m2 = m1;
                m1 = vecs[k].raw;
            end
            sb.push_back(e);

            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL scoreboard step %0d: got empty queue expected entry", k);
            end else begin
                got = sb.pop_front();
                check("dip",      k, dip,            got.dip);
                check("dip_chg",  k, dip_chg,        got.chg);
                check("busy",     k, {7'b0, busy},   {7'b0, got.busy});
                check("dip1",     k, dip1,           got.dip1);
                check("dip_chg1", k, dip_chg1,       got.chg1);
                check("busy1",    k, {7'b0, busy1},  8'h00);
            end
        end

        // Hand sequence: 3-cycle glitch on bit 5 must never reach dip
        dip_ref   = 8'h10;
        chg_seen  = 1'b0;
        busy_seen = 1'b0;
        settled   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dip_raw = 8'h30;
            @(posedge clk);
            #1;
            chg_seen  = chg_seen | (|dip_chg);
            busy_seen = busy_seen | busy;
        end
        @(negedge clk);
        dip_raw = 8'h10;
        for (int i = 0; i < 20 && !settled; i++) begin
            @(posedge clk);
            #1;
            chg_seen  = chg_seen | (|dip_chg);
            busy_seen = busy_seen | busy;
            if (i >= 3 && !busy) settled = 1'b1;
        end
        check("glitch_settle",  0, {7'b0, settled},   8'h01);
        check("glitch_busy",    0, {7'b0, busy_seen}, 8'h01);
        check("glitch_dip",     0, dip,               dip_ref);
        check("glitch_chg",     0, {7'b0, chg_seen},  8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dip_debounce
`default_nettype wire
